// File: rtl/max_pool_2x2.sv
// Streaming 2x2 max-pool: horizontal pair max via hold register, vertical max via half-row line buffer.
// Define POOL_SIGNED_EN for two's-complement comparisons; unsigned otherwise.
module max_pool_2x2 #(
  parameter int DATA_W = 9,
  parameter int ROW_W  = 28,
  parameter int COL_H  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pool_in,
  input  logic              frame_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] pool_out,
  output logic              frame_done
);

  localparam int CW   = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam int RW   = (COL_H > 1) ? $clog2(COL_H) : 1;
  localparam int HALF = ROW_W / 2;
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] line_buf_q [HALF];
  logic [DATA_W-1:0] line_buf_d [HALF];
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] pool_out_q, pool_out_d;
  logic              frame_done_q, frame_done_d;

  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] hmax;
  logic              col_last, row_last;

  function automatic logic [DATA_W-1:0] pmax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
`ifdef POOL_SIGNED_EN
    pmax = ($signed(a) >= $signed(b)) ? a : b;
`else
    pmax = (a >= b) ? a : b;
`endif
  endfunction

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    line_buf_d   = line_buf_q;
    out_valid_d  = 1'b0;
    pool_out_d   = pool_out_q;
    frame_done_d = 1'b0;

    idx      = IW'(col_q >> 1);
    hmax     = pmax(hold_q, pool_in);
    col_last = (col_q == CW'(ROW_W - 1));
    row_last = (row_q == RW'(COL_H - 1));

    // frame_clr takes priority so a coincident sample is dropped
    if (frame_clr) begin
      col_d  = '0;
      row_d  = '0;
      hold_d = '0;
    end else if (in_valid) begin
      if (!col_q[0]) begin
        hold_d = pool_in;
      end else if (!row_q[0]) begin
        line_buf_d[idx] = hmax;
      end else begin
        pool_out_d   = pmax(line_buf_q[idx], hmax);
        out_valid_d  = 1'b1;
        frame_done_d = row_last && col_last;
      end

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      line_buf_q   <= '{default: '0};
      out_valid_q  <= 1'b0;
      pool_out_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      line_buf_q   <= line_buf_d;
      out_valid_q  <= out_valid_d;
      pool_out_q   <= pool_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign pool_out   = pool_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2 on a 4x4 map: a frame-array reference model feeds an expected queue.
module tb_max_pool_2x2;
  localparam int DW = 9;
  localparam int RW = 4;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          frame_clr = 1'b0;
  logic [DW-1:0] pool_in = '0;
  logic          out_valid;
  logic [DW-1:0] pool_out;
  logic          frame_done;

  always #5 clk = ~clk;

  max_pool_2x2 #(.DATA_W(DW), .ROW_W(RW), .COL_H(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pool_in   (pool_in),
    .frame_clr (frame_clr),
    .out_valid (out_valid),
    .pool_out  (pool_out),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [DW-1:0] val;
    logic          last;
    int unsigned   due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] obs[$];
  int unsigned   cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            fd_seen = 0;
  logic [DW-1:0] last_val = '0;
  int            mr = 0;
  int            mc = 0;
  logic [DW-1:0] pix [CH][RW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef POOL_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Maximum of the 2x2 block whose bottom-right pixel is (r, c)
  function automatic logic [DW-1:0] win_max(input int r, input int c);
    logic [DW-1:0] m;
    m = pix[r-1][c-1];
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (gt(pix[r-1+dr][c-1+dc], m)) m = pix[r-1+dr][c-1+dc];
    return m;
  endfunction

  task automatic step(input bit v, input logic [DW-1:0] d, input bit clr);
    in_valid  = v;
    pool_in   = d;
    frame_clr = clr;
    if (clr) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      pix[mr][mc] = d;
      if (mr % 2 == 1 && mc % 2 == 1)
        sb.push_back('{val: win_max(mr, mc), last: (mr == CH-1 && mc == RW-1), due: cyc + 1});
      mc++;
      if (mc == RW) begin
        mc = 0;
        mr = (mr + 1) % CH;
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    frame_clr = 1'b0;
  endtask

  task automatic send_px(input logic [DW-1:0] d, input int gmax);
    repeat ($urandom_range(gmax, 0)) step(1'b0, DW'($urandom()), 1'b0);
    step(1'b1, d, 1'b0);
  endtask

  task automatic drain();
    repeat (4) step(1'b0, DW'($urandom()), 1'b0);
  endtask

  task automatic expect4(input string name, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    check({name, " count"}, 32'(obs.size()), 32'd4);
    if (obs.size() == 4)
      for (int k = 0; k < 4; k++) check({name, " value"}, 32'(obs[k]), 32'(e[k]));
    obs.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_val = '0;
    end else begin
      exp_t e;
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("missing out_valid", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      if (out_valid) begin
        obs.push_back(pool_out);
        if (frame_done) fd_seen++;
        if (sb.size() == 0) begin
          check("spurious out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pool_out", 32'(pool_out), 32'(e.val));
          check("frame_done", 32'(frame_done), 32'(e.last));
          check("latency", cyc, e.due);
          last_val = e.val;
        end
      end else begin
        check("frame_done idle", 32'(frame_done), 32'd0);
        check("pool_out hold", 32'(pool_out), 32'(last_val));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp8[8];
    int fd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset pool_out", 32'(pool_out), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // raster 0..15, continuous
    obs.delete();
    for (int i = 0; i < 16; i++) send_px(DW'(i), 0);
    drain();
    expect4("stream", 5, 7, 13, 15);

    // same frame with random gaps
    for (int i = 0; i < 16; i++) send_px(DW'(i), 3);
    drain();
    expect4("gaps", 5, 7, 13, 15);

    // signedness window {1FF,3 / 2,1}
    send_px(9'h1FF, 1); send_px(9'd3, 1);
    send_px(DW'($urandom()), 1); send_px(DW'($urandom()), 1);
    send_px(9'd2, 1); send_px(9'd1, 1);
    for (int i = 6; i < 16; i++) send_px(DW'($urandom()), 1);
    drain();
    check("window count", 32'(obs.size()), 32'd4);
`ifdef POOL_SIGNED_EN
    check("window max", 32'(obs[0]), 32'd3);
`else
    check("window max", 32'(obs[0]), 32'h1FF);
`endif
    obs.delete();

    // frame_clr coincident with the row 1, col 1 sample
    for (int i = 0; i < 5; i++) send_px(DW'(100 + i), 1);
    step(1'b1, 9'd400, 1'b1);
    drain();
    check("clr no output", 32'(obs.size()), 32'd0);
    for (int i = 0; i < 16; i++) send_px(DW'(i), 1);
    drain();
    expect4("after clr", 5, 7, 13, 15);

    // reset mid row 1
    for (int i = 0; i < 6; i++) send_px(DW'(200 + i), 0);
    step(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset pool_out", 32'(pool_out), 32'd0);
    check("mid reset frame_done", 32'(frame_done), 32'd0);
    sb.delete();
    mr = 0;
    mc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs.delete();
    for (int i = 0; i < 16; i++) send_px(DW'(i), 2);
    drain();
    expect4("after reset", 5, 7, 13, 15);

    // back-to-back frames
    fd0 = fd_seen;
    for (int i = 0; i < 16; i++) send_px(DW'(i), 0);
    for (int i = 15; i >= 0; i--) send_px(DW'(i), 0);
    drain();
    exp8 = '{5, 7, 13, 15, 15, 13, 7, 5};
    check("b2b count", 32'(obs.size()), 32'd8);
    if (obs.size() == 8)
      for (int k = 0; k < 8; k++) check("b2b value", 32'(obs[k]), 32'(exp8[k]));
    check("b2b frame_done pulses", 32'(fd_seen - fd0), 32'd2);
    obs.delete();

    // random data, random gaps, occasional frame_clr
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(29, 0) == 0) step(1'(($urandom() & 1)), DW'($urandom()), 1'b1);
      else send_px(DW'($urandom()), 2);
    end
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) send_px(DW'($urandom()), 1);
    drain();
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
